// File: rtl/ssp_pkg.sv
// Shared SSP definitions: word and FIFO geometry, and the status-bit layout
// used by both the FIFOs and the status register decode.
package ssp_pkg;

    localparam int SSP_WORD_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;
    localparam int SSP_FIFO_AW    = 2;

    // Bit positions of the FIFO status flags inside the status register.
    localparam int SSP_STAT_FULL      = 0;
    localparam int SSP_STAT_HAS_WORD  = 1;
    localparam int SSP_STAT_OVERFLOW  = 2;
    localparam int SSP_STAT_UNDERFLOW = 3;
    localparam int SSP_STAT_W         = 4;

    typedef logic [SSP_STAT_W-1:0] ssp_fifo_stat_t;

    // Pack the individual FIFO flags into the status-register layout.
    function automatic ssp_fifo_stat_t ssp_fifo_status(
        input logic full,
        input logic has_word,
        input logic overflow,
        input logic underflow
    );
        ssp_fifo_stat_t stat;
        stat                     = '0;
        stat[SSP_STAT_FULL]      = full;
        stat[SSP_STAT_HAS_WORD]  = has_word;
        stat[SSP_STAT_OVERFLOW]  = overflow;
        stat[SSP_STAT_UNDERFLOW] = underflow;
        return stat;
    endfunction

endpackage

// File: rtl/ssp_fifo_if.sv
// Push/pop/status bundle of one SSP FIFO. The master is whoever drives the
// push and pop requests; the slave is the FIFO itself.
interface ssp_fifo_if
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_WORD_W,
    parameter int AW    = SSP_FIFO_AW
) ();

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             has_word;
    logic             full;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    logic             flag_clr;

    modport master (
        output wr_en, wr_data, rd_en, flag_clr,
        input  rd_data, has_word, full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, flag_clr,
        output rd_data, has_word, full, count, overflow, underflow
    );

endinterface

// File: rtl/ssp_fifo_ptr.sv
// Wrapping AW-bit FIFO pointer: advances by one when inc is high and rolls
// over from DEPTH-1 to 0 through natural binary wrap.
module ssp_fifo_ptr
    import ssp_pkg::*;
#(
    parameter int AW = SSP_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_reg;

    // Advance the pointer on each accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/ssp_fifo.sv
// First-word-fall-through word FIFO between the APB registers and the SSP
// serial logic. The oldest word is always on rd_data; count, has_word and
// full are registered from the next-state count so they move together with
// the pointers. overflow/underflow are sticky error flags.
module ssp_fifo
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_WORD_W,
    parameter int DEPTH = SSP_FIFO_DEPTH,
    parameter int AW    = SSP_FIFO_AW
) (
    input  logic     pclk,
    input  logic     clear,
    ssp_fifo_if.slave bus
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [AW:0] count_reg;
    logic [AW:0] count_next;
    logic        has_word_reg;
    logic        full_reg;
    logic        overflow_reg;
    logic        underflow_reg;

    logic do_push;
    logic do_pop;
    logic set_overflow;
    logic set_underflow;

    // A pop only happens when something is stored. A push into a full FIFO
    // is still accepted when a pop frees the bottom slot in the same cycle.
    // Pop-while-empty never bypasses a simultaneous push.
    always_comb begin
        do_pop        = bus.rd_en && has_word_reg;
        do_push       = bus.wr_en && (!full_reg || do_pop);
        set_overflow  = bus.wr_en && full_reg && !do_pop;
        set_underflow = bus.rd_en && !has_word_reg;
    end

    // Next-state occupancy: unchanged when both or neither transfer happens.
    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + ONE_CNT;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - ONE_CNT;
        end
    end

    ssp_fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (pclk),
        .rst_n (clear),
        .inc   (do_push),
        .ptr   (wr_ptr)
    );

    ssp_fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (pclk),
        .rst_n (clear),
        .inc   (do_pop),
        .ptr   (rd_ptr)
    );

    // Word storage: reset clears every entry, pops leave entries in place.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Registered occupancy and its derived status flags.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            count_reg    <= '0;
            has_word_reg <= 1'b0;
            full_reg     <= 1'b0;
        end else begin
            count_reg    <= count_next;
            has_word_reg <= (count_next != '0);
            full_reg     <= (count_next == FULL_CNT);
        end
    end

    // Sticky error flags; a new error in the same cycle as flag_clr wins.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (set_overflow) begin
                overflow_reg <= 1'b1;
            end else if (bus.flag_clr) begin
                overflow_reg <= 1'b0;
            end
            if (set_underflow) begin
                underflow_reg <= 1'b1;
            end else if (bus.flag_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign bus.rd_data   = mem[rd_ptr];
    assign bus.count     = count_reg;
    assign bus.has_word  = has_word_reg;
    assign bus.full      = full_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;

endmodule

// File: doc/ssp_fifo.md
Name: ssp_fifo

Overview:
- Synchronous word FIFO between the APB register interface and the SSP transmit/receive logic.
- One instance forms the TX queue: the APB side writes words and the serial transmitter pops them.
- A second instance forms the RX queue: the serial receiver pushes assembled words and the APB side pops them.
- It is first-word-fall-through: the bottom word is always presented on rd_data. Status flags tell the serial logic when a word is waiting and when the queue is full.

Parameters:
- WIDTH, 8, bits per word.
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- pclk  input  1  single clock; all state updates on its rising edge.
- clear  input  1  asynchronous reset, active low.
- wr_en  input  1  push request, sampled at posedge pclk.
- wr_data  input  WIDTH  word to push.
- rd_en  input  1  pop request, sampled at posedge pclk.
- rd_data  output  WIDTH  bottom (oldest) word; valid whenever has_word=1.
- has_word  output  1  high when count is at least 1.
- full  output  1  high when count equals DEPTH.
- count  output  AW+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky; a push was attempted while full.
- underflow  output  1  sticky; a pop was attempted while empty.
- flag_clr  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (clear=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, has_word=0, full=0, overflow=0, underflow=0. All storage entries are 0, so rd_data=0.
- Release of clear takes effect at the next posedge pclk; no state changes while clear=0.
- Storage: DEPTH x WIDTH register array. wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH, so DEPTH-1 goes to 0.
- rd_data is driven combinationally as mem[rd_ptr].
  - After a push into an empty FIFO, rd_data is valid the cycle after the push edge (1-cycle latency).
  - After a pop, the next word appears the cycle after the pop edge.
- has_word, full and count are registered. They are derived from the next-state count, so they are consistent in the same cycle as the pointers.
- Push (wr_en=1 and full=0): mem[wr_ptr] takes wr_data, wr_ptr increments, count increments.
- Pop (rd_en=1 and has_word=1): rd_ptr increments, count decrements. The entry is not cleared.
- Push while full, with no pop in the same cycle: the word is dropped, overflow is set to 1, and pointers and count are unchanged.
- Pop while empty: ignored, underflow is set to 1, and state is unchanged.
  - No bypass: a simultaneous push into an empty FIFO is still accepted. End result is count=1 and underflow=1.
- Simultaneous push and pop while full: both are performed. The pop frees the slot, count stays at DEPTH, full stays 1, and no overflow is flagged.
- Simultaneous push and pop with 0 < count < DEPTH: both are performed and count is unchanged.
- Sticky flags:
  - overflow and underflow hold until flag_clr=1 or reset.
  - If flag_clr and a new error event occur in the same cycle, the set wins and the flag stays 1.
- count never exceeds DEPTH and never goes below 0. The bench treats any violation as a fatal assertion.
- Invariants:
  - full equals (count == DEPTH).
  - has_word equals (count != 0).
  - wr_ptr equals (rd_ptr + count) mod DEPTH.
- Reset mid-operation (clear asserted with words stored): the FIFO empties immediately and all stored words are lost.

Decomposition:
- Shared package ssp_pkg holds:
  - SSP_WORD_W = 8
  - SSP_FIFO_DEPTH = 4
  - SSP_FIFO_AW = 2
  - the status-bit index constants (full, has_word, overflow, underflow), reused by the status register decode.
- One natural sub-module, ssp_fifo_ptr: a wrapping AW-bit pointer with increment enable and asynchronous active-low clear, instantiated twice.
- Storage and flag logic stay in ssp_fifo.

Test Plan:
- Reset then idle: clear=0 for 2 cycles, then clear=1 -> count=0, has_word=0, full=0, rd_data=8'h00, both flags 0.
- Fill and drain: push A1, B2, C3, D4 on consecutive cycles -> full=1 and count=4 after the 4th edge. Pop 4 times -> rd_data shows A1, B2, C3, D4 in order, then has_word=0.
- Overflow: when full, push 5E -> count stays 4, overflow=1, and 5E never appears on rd_data. Assert flag_clr -> overflow=0 next cycle.
- Underflow plus simultaneous push when empty: rd_en=1 and wr_en=1 with wr_data=77 -> count=1, rd_data=77, underflow=1.
- Simultaneous push and pop when full (holding 10,11,12,13), push 14 -> full=1 with no overflow. Draining then yields 11, 12, 13, 14, which confirms pointer wrap.
- Reset mid-operation: with 3 words stored, pulse clear=0 between clock edges -> has_word=0 and count=0 immediately, without waiting for a pclk edge.
